// File: rtl/id_ex_stage_if.sv
// ---------------------------------------------------------------------------
// id_ex_stage_if
// Purpose : bundles the ID-side inputs and EX-side outputs of the ID/EX
//           pipeline register so the stage and its environment connect
//           through one port.
// Ports   : master - drives id_* fields, flush, ex_hold; observes ex_*,
//                    ex_valid, hazard_stall, id_stall, bubble_cnt
//           slave  - the pipeline register itself (opposite directions)
// ---------------------------------------------------------------------------
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
);
  // ID side
  logic              id_valid;
  logic              id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite;
  logic              id_MemRead, id_MemWrite, id_Branch, id_Jump;
  logic [1:0]        id_ALUOp;
  logic [DATA_W-1:0] id_pc4, id_rd1, id_rd2, id_imm;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic [5:0]        id_funct;
  logic              flush;
  logic              ex_hold;
  // EX side
  logic              ex_valid;
  logic              ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite;
  logic              ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump;
  logic [1:0]        ex_ALUOp;
  logic [DATA_W-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
  logic [REG_AW-1:0] ex_rs, ex_rt, ex_rd;
  logic [5:0]        ex_funct;
  logic              hazard_stall;
  logic              id_stall;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    output id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_Jump, id_ALUOp,
           id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
           flush, ex_hold,
    input  ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
           ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump, ex_ALUOp,
           ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
           hazard_stall, id_stall, bubble_cnt
  );

  modport slave (
    input  id_valid, id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite,
           id_MemRead, id_MemWrite, id_Branch, id_Jump, id_ALUOp,
           id_pc4, id_rd1, id_rd2, id_imm, id_rs, id_rt, id_rd, id_funct,
           flush, ex_hold,
    output ex_valid, ex_RegDst, ex_ALUSrc, ex_MemtoReg, ex_RegWrite,
           ex_MemRead, ex_MemWrite, ex_Branch, ex_Jump, ex_ALUOp,
           ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs, ex_rt, ex_rd, ex_funct,
           hazard_stall, id_stall, bubble_cnt
  );
endinterface

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
// Purpose : ID/EX pipeline register of the MIPS-Lite CPU. Captures the
//           decoder control bundle and ID operands, inserts a single bubble
//           on a load-use hazard, honours flush (highest after reset) and
//           EX hold, and sanitises don't-care controls.
// Ports   : clk   - clock, all state on rising edge
//           rst_n - synchronous active-low reset
//           bus   - id_ex_stage_if.slave (ID inputs, flush, ex_hold,
//                   ex_* outputs, hazard_stall, id_stall, bubble_cnt)
// ---------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_stage_if.slave  bus
);

  logic              r_valid;
  logic              r_regdst, r_alusrc, r_memtoreg, r_regwrite;
  logic              r_memread, r_memwrite, r_branch, r_jump;
  logic [1:0]        r_aluop;
  logic [DATA_W-1:0] r_pc4, r_rd1, r_rd2, r_imm;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic [5:0]        r_funct;
  logic [CNT_W-1:0]  r_bubble_cnt;

  logic              w_hazard;
  logic              w_regdst, w_alusrc, w_memtoreg, w_regwrite;
  logic              w_memread, w_memwrite, w_branch, w_jump;
  logic [1:0]        w_aluop;

  // Load in EX whose destination (rt) is read by the ID instruction.
  // Flush and hold both take precedence, so they mask the request.
  always_comb begin
    w_hazard = r_valid & r_memread & bus.id_valid & (r_rt != '0) &
               ((r_rt == bus.id_rs) | (r_rt == bus.id_rt)) &
               ~bus.flush & ~bus.ex_hold;
  end

  // Control sanitisation: RegDst/MemtoReg are don't-care on non-writing
  // instructions, ALUOp is don't-care on branch/jump; force them known.
  always_comb begin
    w_regwrite = bus.id_valid & bus.id_RegWrite;
    w_regdst   = bus.id_valid & bus.id_RegWrite & bus.id_RegDst;
    w_memtoreg = bus.id_valid & bus.id_RegWrite & bus.id_MemtoReg;
    w_alusrc   = bus.id_valid & bus.id_ALUSrc;
    w_memread  = bus.id_valid & bus.id_MemRead;
    w_memwrite = bus.id_valid & bus.id_MemWrite;
    w_branch   = bus.id_valid & bus.id_Branch;
    w_jump     = bus.id_valid & bus.id_Jump;
    w_aluop    = 2'b00;
    if (bus.id_valid) begin
      if (bus.id_Branch)    w_aluop = 2'b01;
      else if (bus.id_Jump) w_aluop = 2'b00;
      else                  w_aluop = bus.id_ALUOp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid      <= 1'b0;
      r_regdst     <= 1'b0;
      r_alusrc     <= 1'b0;
      r_memtoreg   <= 1'b0;
      r_regwrite   <= 1'b0;
      r_memread    <= 1'b0;
      r_memwrite   <= 1'b0;
      r_branch     <= 1'b0;
      r_jump       <= 1'b0;
      r_aluop      <= 2'b00;
      r_pc4        <= '0;
      r_rd1        <= '0;
      r_rd2        <= '0;
      r_imm        <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_rd         <= '0;
      r_funct      <= '0;
      r_bubble_cnt <= '0;
    end else if (bus.flush || (!bus.ex_hold && w_hazard)) begin
      // Kill or bubble: controls cleared, data fields left as they were.
      r_valid    <= 1'b0;
      r_regdst   <= 1'b0;
      r_alusrc   <= 1'b0;
      r_memtoreg <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_branch   <= 1'b0;
      r_jump     <= 1'b0;
      r_aluop    <= 2'b00;
      if (!bus.flush && (r_bubble_cnt != '1))
        r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end else if (!bus.ex_hold) begin
      r_valid    <= bus.id_valid;
      r_regdst   <= w_regdst;
      r_alusrc   <= w_alusrc;
      r_memtoreg <= w_memtoreg;
      r_regwrite <= w_regwrite;
      r_memread  <= w_memread;
      r_memwrite <= w_memwrite;
      r_branch   <= w_branch;
      r_jump     <= w_jump;
      r_aluop    <= w_aluop;
      r_pc4      <= bus.id_pc4;
      r_rd1      <= bus.id_rd1;
      r_rd2      <= bus.id_rd2;
      r_imm      <= bus.id_imm;
      r_rs       <= bus.id_rs;
      r_rt       <= bus.id_rt;
      r_rd       <= bus.id_rd;
      r_funct    <= bus.id_funct;
    end
  end

  assign bus.ex_valid     = r_valid;
  assign bus.ex_RegDst    = r_regdst;
  assign bus.ex_ALUSrc    = r_alusrc;
  assign bus.ex_MemtoReg  = r_memtoreg;
  assign bus.ex_RegWrite  = r_regwrite;
  assign bus.ex_MemRead   = r_memread;
  assign bus.ex_MemWrite  = r_memwrite;
  assign bus.ex_Branch    = r_branch;
  assign bus.ex_Jump      = r_jump;
  assign bus.ex_ALUOp     = r_aluop;
  assign bus.ex_pc4       = r_pc4;
  assign bus.ex_rd1       = r_rd1;
  assign bus.ex_rd2       = r_rd2;
  assign bus.ex_imm       = r_imm;
  assign bus.ex_rs        = r_rs;
  assign bus.ex_rt        = r_rt;
  assign bus.ex_rd        = r_rd;
  assign bus.ex_funct     = r_funct;
  assign bus.hazard_stall = w_hazard;
  assign bus.id_stall     = w_hazard | bus.ex_hold;
  assign bus.bubble_cnt   = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) bus ();

  id_ex_stage #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference model of what EX should hold.
  // ctrl = {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp}
  typedef struct packed {
    logic          valid;
    logic [9:0]    ctrl;
    logic [DW-1:0] pc4, rd1, rd2, imm;
    logic [AW-1:0] rs, rt, rd;
    logic [5:0]    funct;
  } ex_t;

  ex_t        m;
  int         m_cnt;
  logic       exp_haz;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // What the decoder bundle should look like once latched into EX.
  function automatic ex_t capture();
    ex_t  e;
    logic wr;
    logic [1:0] op;
    e       = '0;
    e.valid = bus.id_valid;
    wr      = bus.id_RegWrite;
    op      = bus.id_Branch ? 2'b01 : (bus.id_Jump ? 2'b00 : bus.id_ALUOp);
    if (bus.id_valid)
      e.ctrl = {bus.id_RegDst & wr, bus.id_ALUSrc, bus.id_MemtoReg & wr, wr,
                bus.id_MemRead, bus.id_MemWrite, bus.id_Branch, bus.id_Jump, op};
    e.pc4 = bus.id_pc4; e.rd1 = bus.id_rd1; e.rd2 = bus.id_rd2; e.imm = bus.id_imm;
    e.rs = bus.id_rs; e.rt = bus.id_rt; e.rd = bus.id_rd; e.funct = bus.id_funct;
    return e;
  endfunction

  task automatic set_id(input logic v, input logic [9:0] c,
                        input logic [4:0] rs, input logic [4:0] rt);
    bus.id_valid = v;
    {bus.id_RegDst, bus.id_ALUSrc, bus.id_MemtoReg, bus.id_RegWrite, bus.id_MemRead,
     bus.id_MemWrite, bus.id_Branch, bus.id_Jump, bus.id_ALUOp} = c;
    bus.id_rs    = rs;
    bus.id_rt    = rt;
    bus.id_rd    = 5'($urandom);
    bus.id_pc4   = $urandom;
    bus.id_rd1   = $urandom;
    bus.id_rd2   = $urandom;
    bus.id_imm   = $urandom;
    bus.id_funct = 6'($urandom);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".valid"}, 160'(bus.ex_valid), 160'(m.valid));
    chk({tag, ".ctrl"}, 160'({bus.ex_RegDst, bus.ex_ALUSrc, bus.ex_MemtoReg, bus.ex_RegWrite,
                              bus.ex_MemRead, bus.ex_MemWrite, bus.ex_Branch, bus.ex_Jump,
                              bus.ex_ALUOp}), 160'(m.ctrl));
    chk({tag, ".data"}, 160'({bus.ex_pc4, bus.ex_rd1, bus.ex_rd2, bus.ex_imm, bus.ex_rs,
                              bus.ex_rt, bus.ex_rd, bus.ex_funct}),
        160'({m.pc4, m.rd1, m.rd2, m.imm, m.rs, m.rt, m.rd, m.funct}));
    chk({tag, ".cnt"}, 160'(bus.bubble_cnt), 160'(m_cnt));
  endtask

  // One clock: check combinational stall outputs, take the edge, advance
  // the model by the priority rules, then check registered outputs.
  task automatic cycle(input string tag);
    exp_haz = m.valid && m.ctrl[5] && bus.id_valid && (m.rt != 0) &&
              (m.rt == bus.id_rs || m.rt == bus.id_rt) && !bus.flush && !bus.ex_hold;
    #1;
    chk({tag, ".hazard_stall"}, 160'(bus.hazard_stall), 160'(exp_haz));
    chk({tag, ".id_stall"}, 160'(bus.id_stall), 160'(exp_haz | bus.ex_hold));
    @(posedge clk);
    if (!rst_n) begin
      m = '0; m_cnt = 0;
    end else if (bus.flush) begin
      m.valid = 1'b0; m.ctrl = '0;
    end else if (bus.ex_hold) begin
      m = m;
    end else if (exp_haz) begin
      m.valid = 1'b0; m.ctrl = '0;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
    end else begin
      m = capture();
    end
    #1;
    check_outputs(tag);
  endtask

  localparam logic [9:0] C_LW   = 10'b0111100000; // ALUSrc MemtoReg RegWrite MemRead, ALUOp 00
  localparam logic [9:0] C_RTYP = 10'b1001000010; // RegDst RegWrite, ALUOp 10
  localparam logic [9:0] C_BEQ  = 10'b1010001011; // RegDst/MemtoReg/ALUOp garbage, Branch
  localparam logic [9:0] C_J    = 10'b0000000111; // Jump, ALUOp garbage

  initial begin
    m = '0; m_cnt = 0;
    rst_n = 1'b0;
    bus.flush = 1'b0; bus.ex_hold = 1'b0;
    set_id(1'b1, C_RTYP, 5'd3, 5'd4);

    // Reset while ID presents a writing instruction
    cycle("rst0");
    cycle("rst1");
    chk("rst.valid_zero", 160'(bus.ex_valid), 160'(0));
    rst_n = 1'b1;
    cycle("rst_release");
    chk("rst.first_capture_rs", 160'(bus.ex_rs), 160'(3));

    // Load-use on rs
    set_id(1'b1, C_LW, 5'd1, 5'd9);
    cycle("lw9");
    set_id(1'b1, C_RTYP, 5'd9, 5'd2);
    cycle("lu_bubble");
    chk("lu.cnt_one", 160'(bus.bubble_cnt), 160'(1));
    cycle("lu_capture");
    chk("lu.ex_rs9", 160'(bus.ex_rs), 160'(9));

    // Load with rt=0 never stalls
    set_id(1'b1, C_LW, 5'd1, 5'd0);
    cycle("lw0");
    set_id(1'b1, C_RTYP, 5'd0, 5'd0);
    cycle("lw0_dep");
    chk("lw0.cnt_still_one", 160'(bus.bubble_cnt), 160'(1));

    // Sanitisation
    set_id(1'b1, C_BEQ, 5'd5, 5'd6);
    cycle("beq");
    chk("beq.aluop01", 160'(bus.ex_ALUOp), 160'(2'b01));
    set_id(1'b1, C_J, 5'd7, 5'd8);
    cycle("j");
    chk("j.aluop00_jump", 160'({bus.ex_ALUOp, bus.ex_Jump}), 160'(3'b001));

    // Hold for three cycles, flush on the second
    set_id(1'b1, C_RTYP, 5'd10, 5'd11);
    cycle("pre_hold");
    bus.ex_hold = 1'b1;
    set_id(1'b1, C_LW, 5'd12, 5'd13);
    cycle("hold1");
    bus.flush = 1'b1;
    cycle("hold2_flush");
    chk("hold_flush.valid0", 160'(bus.ex_valid), 160'(0));
    bus.flush = 1'b0;
    cycle("hold3");
    bus.ex_hold = 1'b0;

    // Flush masks a pending load-use
    set_id(1'b1, C_LW, 5'd1, 5'd9);
    cycle("lw9b");
    set_id(1'b1, C_RTYP, 5'd9, 5'd9);
    bus.flush = 1'b1;
    cycle("flush_masks_stall");
    bus.flush = 1'b0;

    // Saturation: 17 load-use pairs
    for (int i = 0; i < 17; i++) begin
      set_id(1'b1, C_LW, 5'd2, 5'd9);
      cycle("sat_lw");
      set_id(1'b1, C_RTYP, 5'd9, 5'd3);
      cycle("sat_bubble");
      cycle("sat_dep");
    end
    chk("sat.cnt_F", 160'(bus.bubble_cnt), 160'(4'hF));

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      bus.flush   = ($urandom_range(0, 9) == 0);
      bus.ex_hold = ($urandom_range(0, 7) == 0);
      set_id(($urandom_range(0, 5) != 0), 10'($urandom),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) bus.id_MemRead = 1'b1;
      cycle("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register sitting directly downstream of the single-cycle control decoder in the pipelined MIPS-Lite CPU.
- Captures the decoder's control bundle plus ID-stage operands each cycle and presents them to EX.
- Detects load-use hazards, inserts bubbles, honours branch/jump flush and downstream hold.
- Sanitises don't-care control bits so EX never sees X.

Parameters:
DATA_W, 32, width of operand/PC/immediate fields
REG_AW, 5, register-file address width
CNT_W, 16, width of bubble performance counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous reset, active-low
id_valid  in  1  ID holds a real instruction
id_RegDst, id_ALUSrc, id_MemtoReg, id_RegWrite, id_MemRead, id_MemWrite, id_Branch, id_Jump  in  1 each  decoder controls
id_ALUOp  in  2  decoder ALUOp
id_pc4  in  DATA_W  PC+4 of ID instruction
id_rd1, id_rd2  in  DATA_W  register-file read data
id_imm  in  DATA_W  sign-extended immediate
id_rs, id_rt, id_rd  in  REG_AW  register specifiers
id_funct  in  6  funct field
flush  in  1  branch/jump taken; kill instruction entering EX
ex_hold  in  1  EX busy (e.g. MULTU iterating); freeze stage
ex_* (RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp, pc4, rd1, rd2, imm, rs, rt, rd, funct)  out  same widths  registered copies
ex_valid  out  1  EX holds a real instruction
hazard_stall  out  1  combinational load-use stall request
id_stall  out  1  hazard_stall | ex_hold; freezes PC and IF/ID
bubble_cnt  out  CNT_W  count of inserted load-use bubbles

Behaviour:
- Reset (rst_n=0 at edge): all ex_* outputs 0, ex_valid=0, bubble_cnt=0. Reset mid-operation overrides flush/hold/capture.
- hazard_stall is combinational:
  - Condition: ex_valid & ex_MemRead & id_valid & ex_rt!=0 & (ex_rt==id_rs | ex_rt==id_rt) & !flush & !ex_hold.
  - Both rs and rt are compared regardless of format (conservative).
- Per-edge priority, highest first:
  1. reset
  2. flush
  3. ex_hold
  4. hazard_stall
  5. normal capture
- flush: all ex control bits <= 0, ex_valid <= 0; data fields are don't-care and retain their values. Flush with ex_hold=1 still clears the stage.
- ex_hold (no flush): every ex_* register and ex_valid keep their value; bubble_cnt unchanged.
- hazard_stall: bubble loaded (all control 0, ex_valid=0, data retained); bubble_cnt += 1, saturating at all-ones. IF/ID is frozen by id_stall, so the same instruction is re-presented next cycle, when ex_MemRead=0 and capture proceeds. Exactly one bubble is inserted per load-use.
- Normal capture: ex_valid <= id_valid; data fields copied directly. Control sanitisation applied at capture:
  - id_valid=0: all controls captured as 0.
  - ex_RegDst, ex_MemtoReg <= input & id_RegWrite (forced 0 when not writing).
  - ex_ALUOp <= 2'b01 if id_Branch=1; 2'b00 if id_Jump=1; else id_ALUOp.
  - The remaining controls (ALUSrc, RegWrite, MemRead, MemWrite, Branch, Jump) pass through unchanged; the decoder defines them as 0/1 for every implemented opcode.
- Latency: one cycle from ID inputs to ex_* outputs.
- No combinational path from id_* data to ex_* outputs.
- id_stall depends only on current ex_* registers plus id_rs/id_rt/id_valid/flush/ex_hold.

Test Plan:
- Reset: rst_n=0 for 2 edges with id_valid=1, id_RegWrite=1 -> all ex_* =0, ex_valid=0, bubble_cnt=0; first edge after release captures the ID values.
- Load-use: LW $t1(rt=9) captured, next ID has rs=9 -> hazard_stall=1, one bubble (ex_valid=0, ex_MemRead=0), bubble_cnt=1; following edge captures the dependent instruction with ex_rs=9. Same case with rt=0 -> no stall.
- Sanitisation: BEQ with id_RegDst=x, id_MemtoReg=x, id_ALUOp=xx -> ex_RegDst=0, ex_MemtoReg=0, ex_ALUOp=2'b01, ex_Branch=1, no X anywhere. J -> ex_ALUOp=00, ex_Jump=1.
- Flush vs hold: ex_hold=1 for 3 cycles -> ex_* frozen, id_stall=1. Assert flush on the 2nd cycle -> ex_valid=0, all ex controls 0 at that edge.
- Flush suppresses stall: ex holds LW rt=9, ID rs=9, flush=1 -> hazard_stall=0, bubble_cnt unchanged, ex_valid<=0.
- Counter saturation (CNT_W=4): 17 consecutive load-use pairs -> bubble_cnt stops at 4'hF.
